rom_word_fetcher: RTL
=====================

# rom_word_fetcher

Initiator side of the byte-wide dual-port boot ROM read interface. It accepts a word-read request from the core, drives both ROM select ports over two consecutive cycles, and collects the four returned bytes. It then assembles them into a 32-bit word and returns that word over a valid/ready response channel, with an out-of-range flag. It sits between the fetch/load path and the boot ROM.

## Interface
- BUS_WIDTH, 8, ROM byte width; fixed at 8.
- SELECT_WIDTH, 32, ROM select and request address width.
- MEMORY_SIZE, 128, ROM size in bytes; bound for range check.
- BIG_ENDIAN, 1, 1: byte at addr is MSB; 0: byte at addr is LSB.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_addr  in  SELECT_WIDTH  byte address of the word; need not be aligned.
- rsp_valid  out  1  response word present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  4*BUS_WIDTH  assembled word.
- rsp_err  out  1  at least one byte address was at or above MEMORY_SIZE.
- rom_select  out  SELECT_WIDTH  ROM port 0 select, registered.
- rom_selectA  out  SELECT_WIDTH  ROM port A select, registered.
- rom_dataOut  in  BUS_WIDTH  ROM port 0 data.
- rom_dataOutA  in  BUS_WIDTH  ROM port A data.

## Operation
- ROM contract:
  - Read data for a select presented in cycle N is valid throughout cycle N+1.
  - Earlier availability is tolerated.
- States: IDLE, ISSUE, CAP0, CAP1, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch req_addr into a, drive rom_select=a and rom_selectA=a+1, then go to ISSUE.
  - Otherwise selects hold their values.
- ISSUE: drive selects a+2 and a+3, then go to CAP0.
- CAP0: capture b0=rom_dataOut and b1=rom_dataOutA, then go to CAP1.
- CAP1:
  - Capture b2 and b3.
  - Register rsp_data, rsp_err and rsp_valid=1, then go to RESP.
- RESP:
  - Hold rsp_data and rsp_err stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready, clear rsp_valid and go to IDLE.
- req_ready is 1 only in IDLE and when rst_n=1. No request is accepted in RESP, even on the rsp_ready cycle.
- Address arithmetic:
  - a+k is computed modulo 2^SELECT_WIDTH, so addresses wrap around.
  - Each wrapped byte address at or above MEMORY_SIZE forces that byte to 0 in rsp_data and sets rsp_err=1.
  - The ROM is still driven with the wrapped address.
- Assembly: BIG_ENDIAN=1 gives {b0,b1,b2,b3}; BIG_ENDIAN=0 gives {b3,b2,b1,b0}.
- req_addr may change after acceptance without effect.

## Timing
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - rom_select, rom_selectA, rsp_data = 0; rsp_valid, rsp_err = 0.
  - req_ready=0 while rst_n=0.
- Reset mid-operation (any state) aborts the fetch. No response is produced and captured bytes are discarded.
- Latency:
  - Accept at edge E0.
  - rsp_valid=1 after edge E3, i.e. visible in the 4th cycle after the accept cycle.
- Minimum request-to-request period is 5 cycles with rsp_ready held high.
- Simultaneous rst_n=0 and req_valid: reset wins and the request is not accepted.

## Structure
- Package rom_fetch_pkg holds:
  - the state enum (IDLE, ISSUE, CAP0, CAP1, RESP);
  - BYTES_PER_WORD=4;
  - a byte-order assembly function parameterised by BIG_ENDIAN.
- Single module, no sub-modules.
- Benches instantiate the existing boot ROM as the responder.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> rsp_valid=0, rsp_err=0, rsp_data=0, both selects 0, req_ready=0; after release, req_ready=1.
- Aligned read: ROM data[i]=i, BIG_ENDIAN=1, req_addr=0x10 -> rsp_data=0x10111213, rsp_err=0, rsp_valid visible in the 4th cycle after accept; with BIG_ENDIAN=0 -> 0x13121110.
- Upper-bound read: req_addr=0x7E, MEMORY_SIZE=128 -> rsp_data=0x7E7F0000, rsp_err=1.
- Address wrap: req_addr=0xFFFFFFFE -> byte addresses 0xFFFFFFFE, 0xFFFFFFFF, 0, 1; rsp_data=0x00000001 (BIG_ENDIAN=1), rsp_err=1.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_data and rsp_err stable, req_ready=0 with req_valid=1 held; a second request is accepted only after the rsp handshake, in IDLE.
- Reset in CAP0: pulse rst_n=0 for 1 cycle -> no rsp_valid ever for that request; the next request to 0x20 returns 0x20212223.

Source files
------------

// File: rtl/rom_fetch_pkg.sv
// Shared types and helpers for the boot ROM word fetcher.
// Holds the FSM encoding, the response payload and byte-order assembly.
package rom_fetch_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CAP0  = 3'd2,
        CAP1  = 3'd3,
        RESP  = 3'd4
    } fetch_state_e;

    // Element k is the byte read from word address + k.
    typedef logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] word_bytes_t;

    typedef struct packed {
        logic              err;
        logic [WORD_W-1:0] data;
    } fetch_rsp_t;

    // Big-endian places the lowest-address byte in the MSB lane.
    function automatic logic [WORD_W-1:0] assemble_word(input logic        big_endian,
                                                        input word_bytes_t bytes);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (big_endian) begin
                w[(BYTES_PER_WORD - 1 - k) * BYTE_W +: BYTE_W] = bytes[k];
            end else begin
                w[k * BYTE_W +: BYTE_W] = bytes[k];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rom_word_fetcher.sv
// Fetches a 32-bit word from a byte-wide dual-port boot ROM over two select
// cycles and returns it, with an out-of-range flag, on a valid/ready channel.
module rom_word_fetcher
    import rom_fetch_pkg::*;
#(
    parameter int unsigned BUS_WIDTH    = 8,
    parameter int unsigned SELECT_WIDTH = 32,
    parameter int unsigned MEMORY_SIZE  = 128,
    parameter bit          BIG_ENDIAN   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SELECT_WIDTH-1:0] req_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [4*BUS_WIDTH-1:0]  rsp_data,
    output logic                    rsp_err,
    output logic [SELECT_WIDTH-1:0] rom_select,
    output logic [SELECT_WIDTH-1:0] rom_selectA,
    input  logic [BUS_WIDTH-1:0]    rom_dataOut,
    input  logic [BUS_WIDTH-1:0]    rom_dataOutA
);

    localparam logic [SELECT_WIDTH-1:0] MEM_LIMIT = SELECT_WIDTH'(MEMORY_SIZE);

    fetch_state_e state_q, state_d;

    logic [SELECT_WIDTH-1:0]   addr_q, addr_d;
    logic [SELECT_WIDTH-1:0]   sel0_q, sel0_d;
    logic [SELECT_WIDTH-1:0]   sel1_q, sel1_d;
    logic [BUS_WIDTH-1:0]      b0_q, b0_d;
    logic [BUS_WIDTH-1:0]      b1_q, b1_d;
    fetch_rsp_t                rsp_q, rsp_d;
    logic                      valid_q, valid_d;
    logic [BYTES_PER_WORD-1:0] out_of_range;
    word_bytes_t               fetched;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = ISSUE;
            ISSUE:   state_d = CAP0;
            CAP0:    state_d = CAP1;
            CAP1:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Wrapped byte addresses past the ROM end are flagged per byte.
    always_comb begin
        out_of_range = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            out_of_range[k] = (addr_q + SELECT_WIDTH'(k)) >= MEM_LIMIT;
        end
    end

    // Bytes 2 and 3 are taken straight from the ROM ports in CAP1.
    always_comb begin
        fetched    = '0;
        fetched[0] = out_of_range[0] ? '0 : b0_q;
        fetched[1] = out_of_range[1] ? '0 : b1_q;
        fetched[2] = out_of_range[2] ? '0 : rom_dataOut;
        fetched[3] = out_of_range[3] ? '0 : rom_dataOutA;
    end

    // Output and datapath next values.
    always_comb begin
        req_ready = 1'b0;
        addr_d    = addr_q;
        sel0_d    = sel0_q;
        sel1_d    = sel1_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        rsp_d     = rsp_q;
        valid_d   = valid_q;
        unique case (state_q)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid) begin
                    addr_d = req_addr;
                    sel0_d = req_addr;
                    sel1_d = req_addr + SELECT_WIDTH'(1);
                end
            end
            ISSUE: begin
                sel0_d = addr_q + SELECT_WIDTH'(2);
                sel1_d = addr_q + SELECT_WIDTH'(3);
            end
            CAP0: begin
                b0_d = rom_dataOut;
                b1_d = rom_dataOutA;
            end
            CAP1: begin
                rsp_d.data = assemble_word(BIG_ENDIAN, fetched);
                rsp_d.err  = |out_of_range;
                valid_d    = 1'b1;
            end
            RESP: begin
                if (rsp_ready) valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset also discards any partially fetched word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            sel0_q  <= '0;
            sel1_q  <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            rsp_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            sel0_q  <= sel0_d;
            sel1_q  <= sel1_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            rsp_q   <= rsp_d;
            valid_q <= valid_d;
        end
    end

    assign rom_select  = sel0_q;
    assign rom_selectA = sel1_q;
    assign rsp_valid   = valid_q;
    assign rsp_data    = rsp_q.data;
    assign rsp_err     = rsp_q.err;

endmodule
